// File: rtl/flow_ctrl_if.sv
// ---------------------------------------------------------------------------
// flow_ctrl_if
//   Groups the pipeline flow controller's request inputs and flow/redirect
//   outputs into one bundle.
//   master : the core side. Drives the hazard, redirect and halt requests and
//            receives the flow codes, PC select and halt acknowledge.
//   slave  : the flow controller side.
//   Signals:
//     jump_en_i, jump_addr_i   EX-stage redirect valid / target
//     load_use_i               load-use hazard between ID and EX
//     div_start_i, div_done_i  multi-cycle divide issue / completion pulse
//     halt_req_i, halt_ack_o   debug halt request (level) / drained acknowledge
//     flow_*_o                 flow codes for PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//     next_pc_four_o, next_pc_o PC source select and redirect target
// ---------------------------------------------------------------------------
interface flow_ctrl_if #(
  parameter int CPU_WIDTH  = 32,
  parameter int FLOW_WIDTH = 2
);
  logic                  jump_en_i;
  logic [CPU_WIDTH-1:0]  jump_addr_i;
  logic                  load_use_i;
  logic                  div_start_i;
  logic                  div_done_i;
  logic                  halt_req_i;
  logic                  halt_ack_o;
  logic [FLOW_WIDTH-1:0] flow_pc_o;
  logic [FLOW_WIDTH-1:0] flow_ifid_o;
  logic [FLOW_WIDTH-1:0] flow_idex_o;
  logic [FLOW_WIDTH-1:0] flow_exmem_o;
  logic [FLOW_WIDTH-1:0] flow_memwb_o;
  logic                  next_pc_four_o;
  logic [CPU_WIDTH-1:0]  next_pc_o;

  modport master (
    output jump_en_i, jump_addr_i, load_use_i, div_start_i, div_done_i, halt_req_i,
    input  halt_ack_o, flow_pc_o, flow_ifid_o, flow_idex_o, flow_exmem_o, flow_memwb_o,
    input  next_pc_four_o, next_pc_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, load_use_i, div_start_i, div_done_i, halt_req_i,
    output halt_ack_o, flow_pc_o, flow_ifid_o, flow_idex_o, flow_exmem_o, flow_memwb_o,
    output next_pc_four_o, next_pc_o
  );
endinterface

// File: rtl/flow_ctrl.sv
// ---------------------------------------------------------------------------
// flow_ctrl
//   Pipeline flow controller. Drives WORK / STOP / REFRESH flow codes to the
//   PC register and the four pipeline registers, resolving EX redirects,
//   load-use bubbles, multi-cycle divide stalls, the post-reset boot hold-off
//   and a debug halt with drain/acknowledge handshake.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    flow_ctrl_if.slave (requests in; flow codes, PC select, ack out)
//   Flow codes are combinational from state + inputs so stalls and flushes
//   act in the same cycle as the hazard; halt_ack_o is registered.
// ---------------------------------------------------------------------------
module flow_ctrl #(
  parameter int CPU_WIDTH    = 32,
  parameter int FLOW_WIDTH   = 2,
  parameter int BOOT_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  flow_ctrl_if.slave   bus
);

  localparam logic [FLOW_WIDTH-1:0] FLOW_WORK    = FLOW_WIDTH'(0);
  localparam logic [FLOW_WIDTH-1:0] FLOW_STOP    = FLOW_WIDTH'(1);
  localparam logic [FLOW_WIDTH-1:0] FLOW_REFRESH = FLOW_WIDTH'(2);

  localparam int BOOT_W  = $clog2(BOOT_CYCLES + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [BOOT_W-1:0]  BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [BOOT_W-1:0]  BOOT_MAX  = BOOT_W'(BOOT_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [BOOT_W-1:0]  boot_cnt_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic               halt_ack_reg;

  // State register plus the counters and the acknowledge flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_BOOT;
      boot_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      halt_ack_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;

      // BOOT is only entered through reset, which already clears the count.
      if (state_reg == ST_BOOT && boot_cnt_reg != BOOT_MAX)
        boot_cnt_reg <= boot_cnt_reg + 1'b1;

      // Cleared on entry to HALTED, saturating while there.
      if (state_reg != ST_HALTED && state_next == ST_HALTED)
        drain_cnt_reg <= '0;
      else if (state_reg == ST_HALTED && drain_cnt_reg != DRAIN_MAX)
        drain_cnt_reg <= drain_cnt_reg + 1'b1;

      // Drops on the same edge that leaves HALTED, since halt_req_i is low then.
      halt_ack_reg <= (state_reg == ST_HALTED) && bus.halt_req_i &&
                      (drain_cnt_reg == DRAIN_MAX);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_BOOT: begin
        if (boot_cnt_reg == BOOT_LAST)
          state_next = ST_RUN;
      end
      ST_RUN: begin
        // jump > div_start > load_use > halt; jump and load_use stay in RUN.
        if (bus.jump_en_i)
          state_next = ST_RUN;
        else if (bus.div_start_i)
          state_next = ST_DIV_WAIT;
        else if (bus.load_use_i)
          state_next = ST_RUN;
        else if (bus.halt_req_i)
          state_next = ST_HALTED;
      end
      ST_DIV_WAIT: begin
        if (bus.div_done_i)
          state_next = ST_RUN;
      end
      ST_HALTED: begin
        if (!bus.halt_req_i)
          state_next = ST_RUN;
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.flow_pc_o      = FLOW_WORK;
    bus.flow_ifid_o    = FLOW_WORK;
    bus.flow_idex_o    = FLOW_WORK;
    bus.flow_exmem_o   = FLOW_WORK;
    bus.flow_memwb_o   = FLOW_WORK;
    bus.next_pc_four_o = 1'b1;
    bus.next_pc_o      = '0;
    case (state_reg)
      ST_BOOT: begin
        bus.flow_pc_o    = FLOW_REFRESH;
        bus.flow_ifid_o  = FLOW_REFRESH;
        bus.flow_idex_o  = FLOW_REFRESH;
        bus.flow_exmem_o = FLOW_REFRESH;
        bus.flow_memwb_o = FLOW_REFRESH;
      end
      ST_RUN: begin
        if (bus.jump_en_i) begin
          // Redirect: flush the two younger stages fetched down the wrong path.
          bus.next_pc_four_o = 1'b0;
          bus.next_pc_o      = bus.jump_addr_i;
          bus.flow_ifid_o    = FLOW_REFRESH;
          bus.flow_idex_o    = FLOW_REFRESH;
        end else if (bus.div_start_i) begin
          bus.flow_pc_o    = FLOW_STOP;
          bus.flow_ifid_o  = FLOW_STOP;
          bus.flow_idex_o  = FLOW_STOP;
          bus.flow_exmem_o = FLOW_REFRESH;
        end else if (bus.load_use_i || bus.halt_req_i) begin
          // Same pattern: hold fetch/decode, inject a bubble into EX.
          bus.flow_pc_o   = FLOW_STOP;
          bus.flow_ifid_o = FLOW_STOP;
          bus.flow_idex_o = FLOW_REFRESH;
        end
      end
      ST_DIV_WAIT: begin
        if (!bus.div_done_i) begin
          bus.flow_pc_o    = FLOW_STOP;
          bus.flow_ifid_o  = FLOW_STOP;
          bus.flow_idex_o  = FLOW_STOP;
          bus.flow_exmem_o = FLOW_REFRESH;
        end
      end
      ST_HALTED: begin
        // Older stages keep working so in-flight instructions drain;
        // PC and IF/ID hold the instruction to resume at.
        bus.flow_pc_o   = FLOW_STOP;
        bus.flow_ifid_o = FLOW_STOP;
        bus.flow_idex_o = FLOW_REFRESH;
      end
      default: ;
    endcase
  end

  assign bus.halt_ack_o = halt_ack_reg;

endmodule
